bp_fpga_host_mmio_serializer: RTL and testbench
===============================================

Name: bp_fpga_host_mmio_serializer

Overview:
- Converts single-beat BlackParrot I/O-out transactions (addr, data, write flag, mask, size), delivered by the AXI-to-FIFO converter, into a stream of fifo_data_width_p-bit words for the host MMIO request FIFO.
- Collects read-response words from the host MMIO response FIFO, assembles them, and returns the completion to the converter.
- Sits between the AXI-to-FIFO converter (upstream and completion side) and the request/response FIFO pair that host software polls.

Parameters:
- fifo_data_width_p, 32, host FIFO word width; legal values are 32 or 64.
- addr_width_p, 64, request address width; must be a multiple of fifo_data_width_p.
- data_width_p, 64, request data width; must be 64.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- addr_i  in  addr_width_p  request address
- data_i  in  data_width_p  write data, LSB-justified
- v_i  in  1  request valid
- w_i  in  1  1 = write, 0 = read
- wmask_i  in  8  byte write mask
- size_i  in  2  log2 of the request size in bytes (0..3)
- ready_and_o  out  1  request accepted when v_i & ready_and_o
- data_o  out  data_width_p  read data for the completion (0 for writes)
- v_o  out  1  completion valid
- w_o  out  1  completion is for a write
- ready_and_i  in  1  completion consumed when v_o & ready_and_i
- req_v_o  out  1  request-FIFO word valid
- req_data_o  out  fifo_data_width_p  request-FIFO word
- req_ready_and_i  in  1  request FIFO can accept a word
- resp_v_i  in  1  response word available
- resp_data_i  in  fifo_data_width_p  response word
- resp_yumi_o  out  1  response word dequeued

Behaviour:
- States: IDLE, HDR, ADDR, DATA, RESP, DONE.
- Reset: state = IDLE, word counter = 0.
  - Outputs after reset: ready_and_o = 1, v_o = 0, req_v_o = 0, resp_yumi_o = 0, data_o = 0, w_o = 0.
- ready_and_o = (state == IDLE).
- IDLE: on v_i & ready_and_o, register addr, data, w, wmask and size; clear the assembled-data register; next state is HDR.
- Header word: bit0 = w, bits[2:1] = size, bits[15:8] = wmask, all other bits 0.
- AW = addr_width_p / fifo_data_width_p (number of address words).
- DW = max(1, (1 << size) * 8 / fifo_data_width_p) (number of data words).
- HDR: req_v_o = 1, req_data_o = header word. On req_ready_and_i, go to ADDR with counter = 0.
- ADDR: req_v_o = 1, req_data_o = address word[counter], least-significant word first. The counter advances on each req_ready_and_i.
  - After the last word (counter == AW-1): a write goes to DATA, a read goes to RESP, counter resets to 0.
- DATA: req_v_o = 1, req_data_o = data word[counter], least-significant word first, full word sent unmasked.
  - After word DW-1, go to DONE.
- RESP: resp_yumi_o = resp_v_i.
  - Each dequeued word is written into slice [counter] of the assembled data; remaining upper bits stay 0 (zero-extend).
  - After word DW-1, go to DONE.
- DONE: v_o = 1, w_o = registered w, data_o = assembled data (0 for writes). On ready_and_i, go to IDLE.
- req_v_o and resp_yumi_o are 0 in every state except those listed above.
- req_v_o is never withdrawn while req_ready_and_i is low, and req_data_o stays stable while stalled.
- resp_yumi_o is never asserted without resp_v_i.
- Writes never consume response words.
- Latency with all handshakes ready (accept in cycle 0):
  - 8B write, fifo 32: HDR c1, ADDR c2-c3, DATA c4-c5, v_o in c6.
  - 4B read, fifo 32: HDR c1, ADDR c2-c3, RESP c4, v_o in c5.
  - fifo 64: AW = 1, DW = 1.
- Only one transaction is in flight; no new request is accepted until the completion handshake.
- Reset mid-transaction: return to IDLE; the partial request is dropped and no further words are emitted.
- size_i > 3 cannot occur (2-bit field). Alignment is guaranteed by the sender and is not checked.

Test Plan:
- Reset with v_i = 1 held → ready_and_o = 1, v_o = 0, req_v_o = 0 on the first cycle after reset.
- fifo 32, write addr = 0x0000_0010_0000_1000, data = 0x1122_3344_5566_7788, size = 3, wmask = 0xFF, all ready → request words 0x0000_FF07, 0x0000_1000, 0x0000_0010, 0x5566_7788, 0x1122_3344; v_o = 1, w_o = 1, data_o = 0 in c6.
- fifo 32, read addr = 0x2000, size = 2; response FIFO supplies 0xDEAD_BEEF after 5 idle cycles → words 0x0000_0004, 0x2000, 0x0; resp_yumi_o pulses once; data_o = 0x0000_0000_DEAD_BEEF.
- fifo 32, read size = 3, responses 0xAAAA_0001 then 0xBBBB_0002 → data_o = 0xBBBB_0002_AAAA_0001.
- req_ready_and_i toggled randomly, ready_and_i held low for 4 cycles → no word dropped or duplicated; req_data_o stable while stalled; v_o and data_o held until accepted.
- fifo 64, 8B write → exactly 3 words (header, address, data). Separately, assert reset during ADDR → IDLE next cycle with no further req_v_o.

Source files
------------

// File: rtl/bp_fpga_host_mmio_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_fpga_host_mmio_serializer                                 |
// | Description : Turns single-beat I/O-out transactions (addr, data, write    |
// |               flag, byte mask, size) into a word stream for the host MMIO  |
// |               request FIFO, and assembles read-response words from the     |
// |               host MMIO response FIFO into a completion.                   |
// |                                                                            |
// |               Request stream per transaction:                              |
// |                 header {wmask @[15:8], size @[2:1], w @[0]}                 |
// |                 address words, least-significant first                     |
// |                 data words, least-significant first (writes only)          |
// |                                                                            |
// | Ports       : clk, reset            clock / synchronous active-high reset   |
// |               addr_i .. size_i,     upstream request (valid/ready_and)      |
// |               v_i, ready_and_o                                             |
// |               data_o, v_o, w_o,     completion back to the converter        |
// |               ready_and_i                                                  |
// |               req_v_o, req_data_o,  request FIFO word stream                |
// |               req_ready_and_i                                              |
// |               resp_v_i, resp_data_i,response FIFO words (valid/yumi)        |
// |               resp_yumi_o                                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bp_fpga_host_mmio_serializer #(
  parameter int fifo_data_width_p = 32,
  parameter int addr_width_p      = 64,
  parameter int data_width_p      = 64
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic [addr_width_p-1:0]      addr_i,
  input  logic [data_width_p-1:0]      data_i,
  input  logic                         v_i,
  input  logic                         w_i,
  input  logic [7:0]                   wmask_i,
  input  logic [1:0]                   size_i,
  output logic                         ready_and_o,

  output logic [data_width_p-1:0]      data_o,
  output logic                         v_o,
  output logic                         w_o,
  input  logic                         ready_and_i,

  output logic                         req_v_o,
  output logic [fifo_data_width_p-1:0] req_data_o,
  input  logic                         req_ready_and_i,

  input  logic                         resp_v_i,
  input  logic [fifo_data_width_p-1:0] resp_data_i,
  output logic                         resp_yumi_o
);

  localparam int c_aw     = addr_width_p / fifo_data_width_p;
  localparam int c_fw_lg  = $clog2(fifo_data_width_p);
  localparam logic [7:0] c_aw_last = 8'(c_aw - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_RESP = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e                        r_state;
  logic [7:0]                    r_cnt;
  logic [addr_width_p-1:0]       r_addr;
  logic [data_width_p-1:0]       r_data;
  logic                          r_w;
  logic [7:0]                    r_wmask;
  logic [1:0]                    r_size;
  logic [data_width_p-1:0]       r_rdata;

  logic [7:0]                    w_bits;
  logic [7:0]                    w_dw;
  logic [7:0]                    w_dw_last;
  logic [fifo_data_width_p-1:0]  w_hdr;
  logic [fifo_data_width_p-1:0]  w_addr_word;
  logic [fifo_data_width_p-1:0]  w_data_word;
  logic [fifo_data_width_p-1:0]  w_req_data;
  logic [data_width_p-1:0]       w_resp_slice;
  logic                          w_req_hs;
  logic                          w_resp_hs;

  // Data-word count: payload bits divided by the FIFO width, floored at one
  // word so sub-word requests still move a full (unmasked) FIFO word.
  assign w_bits    = 8'd8 << r_size;
  assign w_dw      = w_bits >> c_fw_lg;
  assign w_dw_last = (w_dw > 8'd1) ? (w_dw - 8'd1) : 8'd0;

  always_comb begin
    w_hdr        = '0;
    w_hdr[0]     = r_w;
    w_hdr[2:1]   = r_size;
    w_hdr[15:8]  = r_wmask;
  end

  assign w_addr_word  = fifo_data_width_p'(r_addr >> (32'(r_cnt) * fifo_data_width_p));
  assign w_data_word  = fifo_data_width_p'(r_data >> (32'(r_cnt) * fifo_data_width_p));
  // Response word placed at its slice; upper slices remain zero.
  assign w_resp_slice = data_width_p'(resp_data_i) << (32'(r_cnt) * fifo_data_width_p);

  always_comb begin
    w_req_data = w_hdr;
    case (r_state)
      S_ADDR:  w_req_data = w_addr_word;
      S_DATA:  w_req_data = w_data_word;
      default: w_req_data = w_hdr;
    endcase
  end

  // All outputs are decodes of registered state, so req_data_o cannot move
  // while a word is stalled: state and counter only change on a handshake.
  assign ready_and_o = (r_state == S_IDLE);
  assign req_v_o     = (r_state == S_HDR) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign req_data_o  = w_req_data;
  assign w_req_hs    = req_v_o & req_ready_and_i;
  assign w_resp_hs   = (r_state == S_RESP) & resp_v_i;
  assign resp_yumi_o = w_resp_hs;
  assign v_o         = (r_state == S_DONE);
  assign w_o         = (r_state == S_DONE) & r_w;
  assign data_o      = (r_state == S_DONE) ? r_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_w     <= 1'b0;
      r_wmask <= '0;
      r_size  <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (v_i) begin
            r_addr  <= addr_i;
            r_data  <= data_i;
            r_w     <= w_i;
            r_wmask <= wmask_i;
            r_size  <= size_i;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_req_hs) begin
            r_cnt   <= '0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_req_hs) begin
            if (r_cnt == c_aw_last) begin
              r_cnt   <= '0;
              r_state <= r_w ? S_DATA : S_RESP;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
            end
          end
        end
        S_DATA: begin
          if (w_req_hs) begin
            if (r_cnt == w_dw_last) begin
              r_cnt   <= '0;
              r_state <= S_DONE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
            end
          end
        end
        S_RESP: begin
          if (w_resp_hs) begin
            r_rdata <= r_rdata | w_resp_slice;
            if (r_cnt == w_dw_last) begin
              r_cnt   <= '0;
              r_state <= S_DONE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
            end
          end
        end
        S_DONE: begin
          if (ready_and_i) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_fpga_host_mmio_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bp_fpga_host_mmio_serializer                              |
// | Description : Directed self-checking bench for the MMIO serializer, with   |
// |               one 32-bit-FIFO instance and one 64-bit-FIFO instance.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bp_fpga_host_mmio_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // 32-bit FIFO instance
  logic [63:0] addr, data, data_o;
  logic        v_i, w_i, ready_and_o, v_o, w_o, ready_and_i;
  logic [7:0]  wmask;
  logic [1:0]  size;
  logic        req_v_o, req_ready_and_i, resp_v_i, resp_yumi_o;
  logic [31:0] req_data_o, resp_data_i;

  // 64-bit FIFO instance
  logic [63:0] b_addr, b_data, b_data_o, b_req_data_o, b_resp_data_i;
  logic        b_v_i, b_w_i, b_ready_and_o, b_v_o, b_w_o, b_ready_and_i;
  logic [7:0]  b_wmask;
  logic [1:0]  b_size;
  logic        b_req_v_o, b_req_ready_and_i, b_resp_v_i, b_resp_yumi_o;

  bp_fpga_host_mmio_serializer #(.fifo_data_width_p(32), .addr_width_p(64), .data_width_p(64)) dut32 (
    .clk(clk), .reset(reset),
    .addr_i(addr), .data_i(data), .v_i(v_i), .w_i(w_i), .wmask_i(wmask), .size_i(size),
    .ready_and_o(ready_and_o),
    .data_o(data_o), .v_o(v_o), .w_o(w_o), .ready_and_i(ready_and_i),
    .req_v_o(req_v_o), .req_data_o(req_data_o), .req_ready_and_i(req_ready_and_i),
    .resp_v_i(resp_v_i), .resp_data_i(resp_data_i), .resp_yumi_o(resp_yumi_o)
  );

  bp_fpga_host_mmio_serializer #(.fifo_data_width_p(64), .addr_width_p(64), .data_width_p(64)) dut64 (
    .clk(clk), .reset(reset),
    .addr_i(b_addr), .data_i(b_data), .v_i(b_v_i), .w_i(b_w_i), .wmask_i(b_wmask), .size_i(b_size),
    .ready_and_o(b_ready_and_o),
    .data_o(b_data_o), .v_o(b_v_o), .w_o(b_w_o), .ready_and_i(b_ready_and_i),
    .req_v_o(b_req_v_o), .req_data_o(b_req_data_o), .req_ready_and_i(b_req_ready_and_i),
    .resp_v_i(b_resp_v_i), .resp_data_i(b_resp_data_i), .resp_yumi_o(b_resp_yumi_o)
  );

  int passed = 0;
  int total  = 0;

  // Edge monitor: captures accepted request words and dequeued responses,
  // and flags stalled words that drop or change.
  logic [31:0] q32[$];
  logic [63:0] q64[$];
  int          yumi_cnt = 0, b_yumi_cnt = 0, ridx = 0, stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(posedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (req_v_o !== 1'b1 || req_data_o !== prev_data)) stall_err++;
      prev_stall = req_v_o && !req_ready_and_i;
      prev_data  = req_data_o;
    end
    if (req_v_o && req_ready_and_i) q32.push_back(req_data_o);
    if (resp_yumi_o) begin yumi_cnt++; ridx++; end
    if (resp_yumi_o && !resp_v_i) stall_err++;
    if (b_req_v_o && b_req_ready_and_i) q64.push_back(b_req_data_o);
    if (b_resp_yumi_o) b_yumi_cnt++;
  end

  // Runs one transaction on the 32-bit instance. Reads get nresp response
  // words offered from cycle resp_start; writes see a junk word on offer the
  // whole time. The completion is held off for `hold` cycles after v_o.
  task automatic run32(input logic [63:0] a, input logic [63:0] d, input logic w,
                       input logic [7:0] m, input logic [1:0] s,
                       input logic [31:0] r0, input logic [31:0] r1, input int nresp,
                       input int resp_start, input bit rnd, input int hold,
                       output int lat, output logic [63:0] dout, output logic wout,
                       output int err, output bit tmo);
    int k;
    bit seen;
    q32.delete(); yumi_cnt = 0; ridx = 0; stall_err = 0;
    err = 0; seen = 1'b0; lat = -1; dout = 'x; wout = 1'bx; tmo = 1'b0;
    addr = a; data = d; w_i = w; wmask = m; size = s; v_i = 1'b1;
    req_ready_and_i = 1'b1; ready_and_i = 1'b0;
    resp_v_i = w; resp_data_i = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    v_i = 1'b0; addr = '0; data = '0; wmask = '0; size = '0;
    k = 1;
    while (1) begin
      if (seen && ready_and_i) break;
      if (k > 300) begin tmo = 1'b1; break; end
      if (!w) begin
        resp_v_i    = (k >= resp_start) && (ridx < nresp);
        resp_data_i = (ridx == 0) ? r0 : r1;
      end
      if (rnd) req_ready_and_i = ($urandom_range(0, 1) == 1);
      if (ready_and_o) err++;
      if (v_o) begin
        if (!seen) begin seen = 1'b1; lat = k; dout = data_o; wout = w_o; end
        else if (data_o !== dout || w_o !== wout) err++;
      end else if (seen) err++;
      ready_and_i = seen && (k - lat >= hold);
      @(posedge clk); #1;
      k++;
    end
    ready_and_i = 1'b0; resp_v_i = 1'b0; req_ready_and_i = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; v_i = 1'b1; b_v_i = 1'b1; resp_v_i = 1'b1; b_resp_v_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; v_i = 1'b0; b_v_i = 1'b0; resp_v_i = 1'b0; b_resp_v_i = 1'b0;
    total++; if (ready_and_o !== 1'b1) $display("FAIL rst_ready: got %b expected 1", ready_and_o); else passed++;
    total++; if (v_o !== 1'b0) $display("FAIL rst_v_o: got %b expected 0", v_o); else passed++;
    total++; if (req_v_o !== 1'b0) $display("FAIL rst_req_v: got %b expected 0", req_v_o); else passed++;
    total++; if (resp_yumi_o !== 1'b0) $display("FAIL rst_yumi: got %b expected 0", resp_yumi_o); else passed++;
    total++; if (data_o !== 64'h0 || w_o !== 1'b0) $display("FAIL rst_data_w: got %h/%b expected 0/0", data_o, w_o); else passed++;
    total++; if (b_ready_and_o !== 1'b1 || b_req_v_o !== 1'b0 || b_v_o !== 1'b0)
      $display("FAIL rst_fifo64: got ready %b req_v %b v_o %b expected 1/0/0", b_ready_and_o, b_req_v_o, b_v_o); else passed++;
  endtask

  task automatic test_write8;
    int lat, err; logic [63:0] dout; logic wout; bit tmo;
    logic [31:0] exp [0:4];
    logic [31:0] got;
    exp = '{32'h0000_FF07, 32'h0000_1000, 32'h0000_0010, 32'h5566_7788, 32'h1122_3344};
    run32(64'h0000_0010_0000_1000, 64'h1122_3344_5566_7788, 1'b1, 8'hFF, 2'd3,
          32'h0, 32'h0, 0, 0, 1'b0, 0, lat, dout, wout, err, tmo);
    total++; if (tmo) $display("FAIL wr8_timeout: got timeout expected completion"); else passed++;
    total++; if (lat !== 6) $display("FAIL wr8_latency: got %0d expected 6", lat); else passed++;
    total++; if (wout !== 1'b1 || dout !== 64'h0) $display("FAIL wr8_completion: got w %b data %h expected 1/0", wout, dout); else passed++;
    total++; if (q32.size() != 5) $display("FAIL wr8_word_count: got %0d expected 5", q32.size()); else passed++;
    for (int i = 0; i < 5; i++) begin
      got = (i < q32.size()) ? q32[i] : 'x;
      total++; if (got !== exp[i]) $display("FAIL wr8_word%0d: got %h expected %h", i, got, exp[i]); else passed++;
    end
    total++; if (yumi_cnt != 0) $display("FAIL wr8_no_resp_consumed: got %0d expected 0", yumi_cnt); else passed++;
    total++; if (err != 0) $display("FAIL wr8_busy: got %0d errors expected 0", err); else passed++;
    total++; if (ready_and_o !== 1'b1 || v_o !== 1'b0) $display("FAIL wr8_back_idle: got ready %b v_o %b expected 1/0", ready_and_o, v_o); else passed++;
  endtask

  task automatic test_write2;
    int lat, err; logic [63:0] dout; logic wout; bit tmo;
    logic [31:0] exp [0:3];
    logic [31:0] got;
    exp = '{32'h0000_0303, 32'h0000_0010, 32'h0000_0000, 32'hDDDD_1234};
    run32(64'h10, 64'hFFFF_EEEE_DDDD_1234, 1'b1, 8'h03, 2'd1,
          32'h0, 32'h0, 0, 0, 1'b0, 0, lat, dout, wout, err, tmo);
    total++; if (lat !== 5) $display("FAIL wr2_latency: got %0d expected 5", lat); else passed++;
    total++; if (q32.size() != 4) $display("FAIL wr2_word_count: got %0d expected 4", q32.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      got = (i < q32.size()) ? q32[i] : 'x;
      total++; if (got !== exp[i]) $display("FAIL wr2_word%0d: got %h expected %h", i, got, exp[i]); else passed++;
    end
  endtask

  task automatic test_read4;
    int lat, err; logic [63:0] dout; logic wout; bit tmo;
    logic [31:0] exp [0:2];
    logic [31:0] got;
    exp = '{32'h0000_0004, 32'h0000_2000, 32'h0000_0000};
    run32(64'h2000, 64'h0, 1'b0, 8'h00, 2'd2,
          32'hDEAD_BEEF, 32'h0, 1, 9, 1'b0, 0, lat, dout, wout, err, tmo);
    total++; if (lat !== 10) $display("FAIL rd4_latency: got %0d expected 10", lat); else passed++;
    total++; if (dout !== 64'h0000_0000_DEAD_BEEF) $display("FAIL rd4_data: got %h expected 00000000deadbeef", dout); else passed++;
    total++; if (wout !== 1'b0) $display("FAIL rd4_w: got %b expected 0", wout); else passed++;
    total++; if (yumi_cnt != 1) $display("FAIL rd4_yumi_count: got %0d expected 1", yumi_cnt); else passed++;
    total++; if (q32.size() != 3) $display("FAIL rd4_word_count: got %0d expected 3", q32.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      got = (i < q32.size()) ? q32[i] : 'x;
      total++; if (got !== exp[i]) $display("FAIL rd4_word%0d: got %h expected %h", i, got, exp[i]); else passed++;
    end
    total++; if (stall_err != 0) $display("FAIL rd4_protocol: got %0d errors expected 0", stall_err); else passed++;
  endtask

  task automatic test_read8;
    int lat, err; logic [63:0] dout; logic wout; bit tmo;
    logic [31:0] got;
    run32(64'h4000, 64'h0, 1'b0, 8'h00, 2'd3,
          32'hAAAA_0001, 32'hBBBB_0002, 2, 4, 1'b0, 0, lat, dout, wout, err, tmo);
    total++; if (lat !== 6) $display("FAIL rd8_latency: got %0d expected 6", lat); else passed++;
    total++; if (dout !== 64'hBBBB_0002_AAAA_0001) $display("FAIL rd8_data: got %h expected bbbb0002aaaa0001", dout); else passed++;
    total++; if (yumi_cnt != 2) $display("FAIL rd8_yumi_count: got %0d expected 2", yumi_cnt); else passed++;
    got = (q32.size() > 0) ? q32[0] : 'x;
    total++; if (got !== 32'h0000_0006) $display("FAIL rd8_header: got %h expected 00000006", got); else passed++;
  endtask

  task automatic test_back_to_back_stall;
    int lat, err; logic [63:0] dout; logic wout; bit tmo;
    logic [31:0] exp [0:4];
    logic [31:0] got;
    exp = '{32'h0000_0F07, 32'h8765_4320, 32'h0000_0003, 32'h1234_5678, 32'hCAFE_F00D};
    run32(64'h0000_0003_8765_4320, 64'hCAFE_F00D_1234_5678, 1'b1, 8'h0F, 2'd3,
          32'h0, 32'h0, 0, 0, 1'b1, 4, lat, dout, wout, err, tmo);
    total++; if (tmo) $display("FAIL stall_timeout: got timeout expected completion"); else passed++;
    total++; if (q32.size() != 5) $display("FAIL stall_word_count: got %0d expected 5", q32.size()); else passed++;
    for (int i = 0; i < 5; i++) begin
      got = (i < q32.size()) ? q32[i] : 'x;
      total++; if (got !== exp[i]) $display("FAIL stall_word%0d: got %h expected %h", i, got, exp[i]); else passed++;
    end
    total++; if (stall_err != 0) $display("FAIL stall_req_stable: got %0d errors expected 0", stall_err); else passed++;
    total++; if (err != 0) $display("FAIL stall_completion_held: got %0d errors expected 0", err); else passed++;
    total++; if (wout !== 1'b1 || dout !== 64'h0) $display("FAIL stall_completion: got w %b data %h expected 1/0", wout, dout); else passed++;
  endtask

  task automatic test_reset_mid;
    int n, err;
    q32.delete(); err = 0;
    addr = 64'h0000_0010_0000_1000; data = 64'h1; w_i = 1'b1; wmask = 8'hFF; size = 2'd3;
    v_i = 1'b1; req_ready_and_i = 1'b1; ready_and_i = 1'b1;
    @(posedge clk); #1; v_i = 1'b0;
    @(posedge clk); #1;
    total++; if (req_v_o !== 1'b1 || req_data_o !== 32'h0000_1000)
      $display("FAIL rstmid_in_addr: got req_v %b data %h expected 1/00001000", req_v_o, req_data_o); else passed++;
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    n = q32.size();
    total++; if (ready_and_o !== 1'b1 || req_v_o !== 1'b0)
      $display("FAIL rstmid_idle: got ready %b req_v %b expected 1/0", ready_and_o, req_v_o); else passed++;
    repeat (6) begin
      if (req_v_o !== 1'b0 || v_o !== 1'b0) err++;
      @(posedge clk); #1;
    end
    total++; if (err != 0 || q32.size() != n)
      $display("FAIL rstmid_quiet: got %0d active cycles, %0d new words expected 0/0", err, q32.size() - n); else passed++;
    ready_and_i = 1'b0;
  endtask

  task automatic test_fifo64;
    int k, lat;
    logic [63:0] dout, got;
    logic wout;
    logic [63:0] exp [0:2];
    exp = '{64'h0000_0000_0000_FF07, 64'h0000_0010_0000_1000, 64'h1122_3344_5566_7788};
    q64.delete(); b_yumi_cnt = 0; lat = -1; dout = 'x; wout = 1'bx;
    b_addr = 64'h0000_0010_0000_1000; b_data = 64'h1122_3344_5566_7788; b_w_i = 1'b1;
    b_wmask = 8'hFF; b_size = 2'd3; b_v_i = 1'b1;
    b_req_ready_and_i = 1'b1; b_ready_and_i = 1'b1; b_resp_v_i = 1'b1; b_resp_data_i = 64'hBAD;
    @(posedge clk); #1; b_v_i = 1'b0;
    k = 1;
    while (k < 30) begin
      if (b_v_o) begin lat = k; dout = b_data_o; wout = b_w_o; break; end
      @(posedge clk); #1; k++;
    end
    @(posedge clk); #1;
    b_resp_v_i = 1'b0;
    total++; if (lat !== 4) $display("FAIL f64_latency: got %0d expected 4", lat); else passed++;
    total++; if (wout !== 1'b1 || dout !== 64'h0) $display("FAIL f64_completion: got w %b data %h expected 1/0", wout, dout); else passed++;
    total++; if (q64.size() != 3) $display("FAIL f64_word_count: got %0d expected 3", q64.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      got = (i < q64.size()) ? q64[i] : 'x;
      total++; if (got !== exp[i]) $display("FAIL f64_word%0d: got %h expected %h", i, got, exp[i]); else passed++;
    end
    total++; if (b_yumi_cnt != 0) $display("FAIL f64_no_resp_consumed: got %0d expected 0", b_yumi_cnt); else passed++;
    total++; if (b_ready_and_o !== 1'b1) $display("FAIL f64_back_idle: got %b expected 1", b_ready_and_o); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    addr = '0; data = '0; v_i = 1'b0; w_i = 1'b0; wmask = '0; size = '0;
    ready_and_i = 1'b0; req_ready_and_i = 1'b1; resp_v_i = 1'b0; resp_data_i = '0;
    b_addr = '0; b_data = '0; b_v_i = 1'b0; b_w_i = 1'b0; b_wmask = '0; b_size = '0;
    b_ready_and_i = 1'b0; b_req_ready_and_i = 1'b1; b_resp_v_i = 1'b0; b_resp_data_i = '0;
    test_reset;
    test_write8;
    test_write2;
    test_read4;
    test_read8;
    test_back_to_back_stall;
    test_reset_mid;
    test_fifo64;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
